conv_out_writer: RTL and testbench

- Write-side counterpart of the convolution controller's input read path.
- Accepts one convolution result bit per cycle from the datapath and packs each output row MSB-first into 16-bit words.
- Issues single-cycle writes to the output SRAM at incrementing addresses and flushes partial words at row and frame end.
- Sits between the conv modules/controller strobes and the dut_sram_write_* port.

---
 rtl/conv_out_pkg.sv | 19 +
 rtl/conv_out_writer_bit_packer.sv | 49 ++++
 rtl/conv_out_writer.sv | 132 +++++++++++++
 tb/tb_conv_out_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_out_pkg.sv
// Shared definitions for the convolution output writer: default widths,
// FSM state encoding and the frame terminator word.
package conv_out_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  localparam logic [15:0] END_MARKER = 16'h00FF;

  // TERM is only reachable when CONV_OUT_TERMINATOR_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    TERM  = 3'd3,
    DONE  = 3'd4
  } conv_state_e;

endpackage

// File: rtl/conv_out_writer_bit_packer.sv
// MSB-first bit packer: the first pushed bit of a word lands in bit DATA_W-1.
// clr and push in the same cycle start a fresh word holding the pushed bit.
module bit_packer
  import conv_out_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clr,
  input  logic              push,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic [CNT_W-1:0]  count_next,
  output logic              full,
  output logic              pending
);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] base_word;
  logic [CNT_W-1:0]  base_cnt;
  logic [DATA_W-1:0] word_nx;

  always_comb begin
    base_word  = clr ? '0 : word;
    base_cnt   = clr ? '0 : count;
    word_nx    = base_word;
    count_next = base_cnt;
    if (push && (base_cnt < CNT_W'(DATA_W))) begin
      word_nx    = base_word | ({bit_in, {(DATA_W-1){1'b0}}} >> base_cnt);
      count_next = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      word  <= '0;
      count <= '0;
    end else begin
      word  <= word_nx;
      count <= count_next;
    end
  end

  assign full    = (count == CNT_W'(DATA_W));
  assign pending = (count != '0);

endmodule

// File: rtl/conv_out_writer.sv
// Packs convolution result bits into words and writes them to the output SRAM.
// Optional frame terminator write is enabled by defining CONV_OUT_TERMINATOR_EN.
module conv_out_writer
  import conv_out_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  input  logic              row_end_i,
  input  logic              frame_end_i,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output conv_state_e       dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef CONV_OUT_TERMINATOR_EN
  localparam conv_state_e FINAL_STATE = TERM;
`else
  localparam conv_state_e FINAL_STATE = DONE;
`endif

  conv_state_e       state, state_nx;
  logic              row_req, row_req_nx;
  logic [ADDR_W-1:0] addr;
  logic              pk_clr, pk_push, write_go, commit;
  logic [DATA_W-1:0] pk_word, write_word;
  logic [CNT_W-1:0]  pk_count_nx;
  logic              pk_full, pk_pending;

  bit_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .reset_b    (reset_b),
    .clr        (pk_clr),
    .push       (pk_push),
    .bit_in     (bit_i),
    .word       (pk_word),
    .count_next (pk_count_nx),
    .full       (pk_full),
    .pending    (pk_pending)
  );

  // Strobes are single-cycle and unacknowledged: a word becomes due on the edge
  // that fills it (or sees row_end) and is written on the edge after that.
  assign commit     = pk_full | row_req;
  assign write_word = (state == TERM) ? DATA_W'(END_MARKER) : pk_word;
  assign dbg_state  = state;

  always_comb begin
    pk_clr   = 1'b0;
    pk_push  = 1'b0;
    write_go = 1'b0;
    case (state)
      IDLE:  pk_clr = start_i;
      RUN: begin
        pk_clr   = commit;
        pk_push  = bit_valid_i;
        write_go = commit;
      end
      FLUSH: begin
        pk_clr   = 1'b1;
        write_go = pk_pending;
      end
      TERM:    write_go = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    row_req_nx = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = RUN;
      RUN: begin
        if (frame_end_i)
          state_nx = (pk_count_nx != '0) ? FLUSH : FINAL_STATE;
        else
          row_req_nx = row_end_i && (pk_count_nx != '0);
      end
      FLUSH:   state_nx = FINAL_STATE;
      TERM:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state                  <= IDLE;
      row_req                <= 1'b0;
      addr                   <= BASE_ADDR;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      busy_o                 <= 1'b0;
      done_o                 <= 1'b0;
      overflow_o             <= 1'b0;
    end else begin
      state                 <= state_nx;
      row_req               <= row_req_nx;
      dut_sram_write_enable <= write_go;
      done_o                <= 1'b0;
      if (state == IDLE && start_i) begin
        addr       <= BASE_ADDR;
        overflow_o <= 1'b0;
        busy_o     <= 1'b1;
      end
      if (write_go) begin
        dut_sram_write_address <= addr;
        dut_sram_write_data    <= write_word;
        addr                   <= addr + ADDR_W'(1);
        if (addr == '1) overflow_o <= 1'b1;
      end
      if (state == DONE) begin
        done_o <= 1'b1;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Bench for conv_out_writer: vector table, frame/wrap/reset sequences and
// randomized frames against a bit-list reference model.
module tb_conv_out_writer;
  import conv_out_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  logic start_i = 1'b0, bit_valid_i = 1'b0, bit_i = 1'b0;
  logic row_end_i = 1'b0, frame_end_i = 1'b0;

  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          we0, we1, busy0, busy1, done0, done1, ovf0, ovf1;
  conv_state_e   dbg0, dbg1;

  conv_out_writer u_dut (
    .clk(clk), .reset_b(reset_b), .start_i(start_i), .bit_valid_i(bit_valid_i),
    .bit_i(bit_i), .row_end_i(row_end_i), .frame_end_i(frame_end_i),
    .dut_sram_write_address(addr0), .dut_sram_write_data(data0),
    .dut_sram_write_enable(we0), .busy_o(busy0), .done_o(done0),
    .overflow_o(ovf0), .dbg_state(dbg0)
  );

  conv_out_writer #(.BASE_ADDR(12'hFFF)) u_wrap (
    .clk(clk), .reset_b(reset_b), .start_i(start_i), .bit_valid_i(bit_valid_i),
    .bit_i(bit_i), .row_end_i(row_end_i), .frame_end_i(frame_end_i),
    .dut_sram_write_address(addr1), .dut_sram_write_data(data1),
    .dut_sram_write_enable(we1), .busy_o(busy1), .done_o(done1),
    .overflow_o(ovf1), .dbg_state(dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          mode;   // 0: row_end with last bit, 1: row_end alone after, 2: none
    logic        exp_wr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_addr;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic cyc(input logic v, input logic b, input logic re, input logic fe, input logic st);
    bit_valid_i = v; bit_i = b; row_end_i = re; frame_end_i = fe; start_i = st;
    @(posedge clk);
    #1;
    bit_valid_i = 1'b0; bit_i = 1'b0; row_end_i = 1'b0; frame_end_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + AW'(1);
  endtask

  // scoreboard on the base-0 instance
  always @(negedge clk) begin
    if (we0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: actual write %0h@%0h required none", data0, addr0);
      end else begin
        chk("sb_write", {addr0, data0}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    while (!done0 && k < 12) begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end
    chk("done_seen", done0, 1'b1);
    chk("done_busy", busy0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("done_pulse_len", done0, 1'b0);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic finish_empty_frame();
    cyc(0, 0, 0, 1, 0);
`ifdef CONV_OUT_TERMINATOR_EN
    push_exp(16'h00FF);
`endif
    wait_done();
  endtask

  // randomized frame checked against a bit-list model
  task automatic rand_frame();
    logic q_bits[$];
    logic [DW-1:0] w;
    logic v, b, re, st, fe;
    int n;
    for (int g = 0; g < 3; g++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'b0);
    cyc(0, 0, 0, 0, 1);
    exp_addr = '0;
    n = $urandom_range(8, 48);
    for (int c = 0; c < n; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 15) == 0);
      fe = (c == n - 1);
      if (v) q_bits.push_back(b);
      if (q_bits.size() == DW || (q_bits.size() > 0 && (re || fe))) begin
        w = '0;
        for (int i = 0; i < q_bits.size(); i++) w[DW-1-i] = q_bits[i];
        push_exp(w);
        q_bits.delete();
      end
      if (fe && q_bits.size() > 0) begin
        w = '0;
        for (int i = 0; i < q_bits.size(); i++) w[DW-1-i] = q_bits[i];
        push_exp(w);
        q_bits.delete();
      end
`ifdef CONV_OUT_TERMINATOR_EN
      if (fe) push_exp(16'h00FF);
`endif
      cyc(v, b, re, fe, st);
    end
    wait_done();
  endtask

  initial begin
    vec_t t;
    logic [AW-1:0] ea;

    vecs[0] = '{16, 16'hAAAA, 2, 1'b1, 16'hAAAA};
    vecs[1] = '{5,  16'hF800, 1, 1'b1, 16'hF800};
    vecs[2] = '{3,  16'hE000, 0, 1'b1, 16'hE000};
    vecs[3] = '{16, 16'hFFFF, 0, 1'b1, 16'hFFFF};
    vecs[4] = '{0,  16'h0000, 1, 1'b0, 16'h0000};
    vecs[5] = '{1,  16'h0000, 0, 1'b1, 16'h0000};
    vecs[6] = '{9,  16'h5A80, 0, 1'b1, 16'h5A80};
    vecs[7] = '{15, 16'h1234, 1, 1'b1, 16'h1234};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we0, 1'b0);
    chk("rst_addr", addr0, '0);
    chk("rst_data", data0, '0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_state", dbg0, IDLE);
    reset_b = 1'b0;
    cyc(0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1);
    exp_addr = '0;
    chk("start_busy", busy0, 1'b1);
    chk("start_state", dbg0, RUN);

    for (int r = 0; r < 8; r++) begin
      t = vecs[r];
      for (int i = 0; i < t.nbits; i++)
        cyc(1'b1, t.bits[15-i], (t.mode == 0 && i == t.nbits - 1), 1'b0, 1'b0);
      if (t.mode == 1) cyc(0, 0, 1, 0, 0);
      chk($sformatf("v%0d_pre_we", r), we0, 1'b0);
      ea = exp_addr;
      if (t.exp_wr) push_exp(t.exp_data);
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("v%0d_we", r), we0, t.exp_wr);
      if (t.exp_wr) begin
        chk($sformatf("v%0d_data", r), data0, t.exp_data);
        chk($sformatf("v%0d_addr", r), addr0, ea);
      end
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("v%0d_we_off", r), we0, 1'b0);
    end

    // frame end with two pending bits
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    ea = exp_addr;
    push_exp(16'hC000);
`ifdef CONV_OUT_TERMINATOR_EN
    push_exp(16'h00FF);
`endif
    cyc(0, 0, 0, 1, 0);
    chk("fe_pre_we", we0, 1'b0);
    chk("fe_busy", busy0, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("fe_flush_we", we0, 1'b1);
    chk("fe_flush_data", data0, 16'hC000);
    chk("fe_flush_addr", addr0, ea);
    chk("fe_flush_nodone", done0, 1'b0);
`ifdef CONV_OUT_TERMINATOR_EN
    cyc(0, 0, 0, 0, 0);
    chk("fe_term_we", we0, 1'b1);
    chk("fe_term_data", data0, 16'h00FF);
    chk("fe_term_addr", addr0, ea + AW'(1));
    chk("fe_term_nodone", done0, 1'b0);
`endif
    cyc(0, 0, 0, 0, 0);
    chk("fe_done", done0, 1'b1);
    chk("fe_done_busy", busy0, 1'b0);
    chk("fe_done_we", we0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("fe_done_len", done0, 1'b0);
    chk("fe_idle", dbg0, IDLE);

    // address wrap on the BASE_ADDR=FFF instance
    cyc(0, 0, 0, 0, 1);
    exp_addr = '0;
    chk("wrap_ovf_clr", ovf1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0);
    chk("wrap_ovf_pre", ovf1, 1'b0);
    push_exp(16'hFFFF);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_w1_we", we1, 1'b1);
    chk("wrap_w1_addr", addr1, 12'hFFF);
    chk("wrap_w1_ovf", ovf1, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0);
    push_exp(16'h0000);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_w2_we", we1, 1'b1);
    chk("wrap_w2_addr", addr1, 12'h000);
    chk("wrap_w2_ovf", ovf1, 1'b1);
    chk("wrap_base0_ovf", ovf0, 1'b0);
    finish_empty_frame();
    chk("wrap_ovf_sticky", ovf1, 1'b1);
    cyc(0, 0, 0, 0, 1);
    exp_addr = '0;
    chk("wrap_ovf_restart", ovf1, 1'b0);

    // reset in the middle of a run
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0);
    reset_b = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset_b = 1'b0;
    chk("mid_rst_we", we0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_addr", addr0, '0);
    chk("mid_rst_data", data0, '0);
    chk("mid_rst_state", dbg0, IDLE);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk("mid_rst_quiet", we0, 1'b0);
    cyc(0, 0, 0, 0, 1);
    exp_addr = '0;
    for (int i = 0; i < 16; i++) cyc(1, 1'(i % 2 == 0), 0, 0, 0);
    push_exp(16'hAAAA);
    cyc(0, 0, 0, 0, 0);
    chk("restart_addr", addr0, '0);
    chk("restart_data", data0, 16'hAAAA);
    finish_empty_frame();

    for (int f = 0; f < 10; f++) rand_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
